// File: rtl/up_ramcfg_pkg.sv
// up_ramcfg_pkg: shared constants and width helper for the config-RAM front end
package up_ramcfg_pkg;
  localparam int STARVE_DEF = 4;
  localparam int STARVE_MAX = 255;
  localparam int NENG_MAX = 8;
  // Bits needed to hold 0..n-1, never less than 1 so single-entry counters stay legal.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/up_ramcfg_rrarb.sv
// up_ramcfg_rrarb: round-robin arbiter, one-hot winner searched from ptr upward
// Ports: req (requests), ptr (search start), win (one-hot winner), any (some request), nxt (winner+1 mod N)
module up_ramcfg_rrarb
  import up_ramcfg_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]          req,
  input  logic [clog2(N)-1:0]   ptr,
  output logic [N-1:0]          win,
  output logic                  any,
  output logic [clog2(N)-1:0]   nxt
);
  localparam int PW = clog2(N);
  logic [2*N-1:0] dbl;
  int sel;
  int idx;
  always_comb begin
    dbl = {req, req} >> ptr;
    sel = 0;
    for (int k = N - 1; k >= 0; k--) if (dbl[k]) sel = k;
    idx = (int'(ptr) + sel) % N;
    any = |req;
    win = any ? N'(1) << idx : '0;
    nxt = any ? PW'((idx + 1) % N) : ptr;
  end
endmodule

// File: rtl/up_ramcfg_nr0w2x.sv
// up_ramcfg_nr0w2x: shares a 2-cycle-latency config RAM among G_NENG engines and the CPU
// Ports: eng_re/eng_ra/eng_gnt/eng_rvld/eng_rdd (engine reads), upen/upa/upws/uprs/updi/updo/uprdy
// (CPU up-protocol), omemwe/omemwa/omemdi/omemre/omemra/imemdo (rtlmem_1r1w2x ports)
module up_ramcfg_nr0w2x
  import up_ramcfg_pkg::*;
#(
  parameter int G_ADDR   = 10,
  parameter int G_WIDTH  = 32,
  parameter int G_NENG   = 2,
  parameter int G_STARVE = STARVE_DEF,
  parameter int G_BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [G_NENG-1:0]        eng_re,
  input  logic [G_NENG*G_ADDR-1:0] eng_ra,
  output logic [G_NENG-1:0]        eng_gnt,
  output logic [G_NENG-1:0]        eng_rvld,
  output logic [G_WIDTH-1:0]       eng_rdd,
  input  logic                     upen,
  input  logic [G_ADDR-1:0]        upa,
  input  logic                     upws,
  input  logic                     uprs,
  input  logic [G_WIDTH-1:0]       updi,
  output logic [G_WIDTH-1:0]       updo,
  output logic                     uprdy,
  output logic                     omemwe,
  output logic [G_ADDR-1:0]        omemwa,
  output logic [G_WIDTH-1:0]       omemdi,
  output logic                     omemre,
  output logic [G_ADDR-1:0]        omemra,
  input  logic [G_WIDTH-1:0]       imemdo
);
  localparam int PW = clog2(G_NENG);
  localparam int SW = clog2(G_STARVE + 1);
  logic [G_NENG-1:0] req, win, g1, g2;
  logic [PW-1:0] rr_ptr, rr_nxt;
  logic [SW-1:0] cnt;
  logic [G_ADDR-1:0] eaddr, waddr;
  logic [G_WIDTH-1:0] d1, d2;
  logic any, wr, pend, force_cpu, served, rd_issue, conflict, lat, c1, c2, b1, b2;
  // Everything combinational is gated by rst so the reset cycle itself shows idle outputs.
  assign req = rst ? '0 : eng_re;
  assign wr = ~rst & upen & upws;
  assign pend = ~rst & upen & ~upws & (uprs | lat);
  assign force_cpu = pend & (cnt == SW'(G_STARVE));
  up_ramcfg_rrarb #(.N(G_NENG)) u_arb (.req(req), .ptr(rr_ptr), .win(win), .any(any), .nxt(rr_nxt));
  always_comb begin
    eaddr = '0;
    for (int i = 0; i < G_NENG; i++) if (win[i]) eaddr = eng_ra[i*G_ADDR +: G_ADDR];
  end
  assign waddr = (force_cpu | ~any) ? upa : eaddr;
  // Merge: every engine aimed at the winning address rides the same memory read.
  always_comb begin
    eng_gnt = '0;
    for (int i = 0; i < G_NENG; i++) eng_gnt[i] = req[i] & (eng_ra[i*G_ADDR +: G_ADDR] == waddr);
  end
  assign served = pend & (upa == waddr);
  assign rd_issue = |eng_gnt | served;
  assign conflict = (G_BYPASS != 0) & wr & (upa == waddr) & rd_issue;
  assign omemre = rd_issue & ~conflict;
  assign omemra = waddr;
  assign omemwe = wr;
  assign omemwa = upa;
  assign omemdi = updi;
  assign eng_rvld = rst ? '0 : g2;
  assign uprdy = ~rst & c2;
  assign eng_rdd = b2 ? d2 : imemdo;
  assign updo = eng_rdd;
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
      cnt <= '0;
      lat <= 1'b0;
      {g1, g2, c1, c2, b1, b2, d1, d2} <= '0;
    end else begin
      if (any & ~force_cpu) rr_ptr <= rr_nxt;
      lat <= upen & ~served & (lat | pend);
      cnt <= (~upen | served) ? '0 : (pend & ~force_cpu) ? cnt + 1'b1 : cnt;
      g1 <= eng_gnt;
      c1 <= wr | served;
      b1 <= conflict;
      d1 <= updi;
      g2 <= g1;
      c2 <= c1;
      b2 <= b1;
      d2 <= d1;
    end
  end
endmodule

// File: doc/up_ramcfg_nr0w2x.md
# up_ramcfg_nr0w2x

Configuration-RAM front end that shares one external 2-cycle-latency read port and one write port among G_NENG logic-engine read ports and the CPU up-protocol interface. It is the multi-engine successor to the single-engine config RAM macro, and adds the following:
- round-robin engine arbitration with a grant handshake;
- address merging, so requests to the same address are served together;
- a bounded CPU-read starvation guarantee;
- a write-to-read bypass selected by parameter.

It sits between the engines and an rtlmem_1r1w2x instance.

## Interface
Parameters:
- G_ADDR, 10: address width.
- G_WIDTH, 32: data width.
- G_NENG, 2: number of engine read ports, 1..8.
- G_STARVE, 4: maximum consecutive cycles a pending CPU read may lose arbitration, 1..255.
- G_BYPASS, 1: 1 enables write-conflict bypass (memory without new-data read behaviour); 0 means the memory resolves the conflict.

Ports:
- clk, in, 1: single clock. All flops are on the rising edge.
- rst, in, 1: reset, synchronous and active-high.
- eng_re, in, G_NENG: per-engine read request.
- eng_ra, in, G_NENG*G_ADDR: engine i address in bits [i*G_ADDR +: G_ADDR].
- eng_gnt, out, G_NENG: combinational grant, same cycle as eng_re.
- eng_rvld, out, G_NENG: read data valid for the engines granted 2 cycles earlier.
- eng_rdd, out, G_WIDTH: engine read data, shared by all ports and qualified by eng_rvld.
- upen, upa, upws, uprs, updi: in, 1/G_ADDR/1/1/G_WIDTH: CPU enable, address, write strobe, read strobe, write data.
- updo, out, G_WIDTH: CPU read data, valid while uprdy=1.
- uprdy, out, 1: one-cycle completion pulse.
- omemwe, omemwa, omemdi: out: memory write port.
- omemre, omemra: out: memory read port.
- imemdo, in, G_WIDTH: memory read data, valid 2 cycles after omemre.

## Operation
CPU write:
- Issued when upen & upws. It is never blocked.
- Drives omemwe=1, omemwa=upa, omemdi=updi in the same cycle.
- If upws and uprs are both asserted, the write wins and the read is ignored.

CPU read:
- The request is pending when upen & uprs, or when the read latch is set.
- The latch sets on a read that is not served.
- The latch clears on service, or when upen=0 (CPU timeout).

Arbitration, evaluated each cycle:
- Forced CPU slot: if the starve counter equals G_STARVE and a CPU read is pending, the CPU wins and eng_gnt is 0 for every engine whose address is not upa.
- Otherwise, the round-robin winner is chosen among eng_re, starting at rr_ptr. rr_ptr advances to winner+1 (mod G_NENG) only when an engine wins.
- If no engine requests, a pending CPU read wins.

Address merging:
- Every requesting engine whose address equals the winning address is granted.
- A pending CPU read whose upa equals the winning address is also served.

Memory read port:
- omemre = (any grant or CPU served) & !wr_conflict.
- omemra = winning address.

Write conflict:
- wr_conflict = G_BYPASS & omemwe & (upa == winning address) & read issued.
- The read is suppressed and updi is captured as bypass data for that slot.

Starve counter:
- Increments, saturating at G_STARVE, on each cycle a CPU read is pending but not served.
- Clears on service, when upen=0, and on rst.

Read return pipeline:
- Two stages carry the grant mask, the CPU-served flag, the bypass flag and the bypass data.
- At stage 2: eng_rvld = grant mask; eng_rdd = updo = bypass ? bypass data : imemdo.

Completion:
- uprdy pulses 2 cycles after a write issue or a CPU read service.
- If upen drops after service, uprdy still pulses and the CPU ignores it.

## Timing
- Cycle 0: request, grant, omemre, omemwe. Cycle 2: eng_rvld, uprdy, data. One access per cycle, fully pipelined.
- CPU read worst-case wait under continuous engine load: G_STARVE+1 cycles from first request to service.
- Reset values:
  - eng_gnt=0, eng_rvld=0, uprdy=0, omemre=0, omemwe=0;
  - eng_rdd=updo=imemdo (mux select 0);
  - rr_ptr=0, starve counter=0, read latch=0, pipeline flags=0.
- Reset mid-operation: in-flight reads are dropped and no rvld/uprdy pulses after rst.
- eng_gnt is combinational from eng_re, eng_ra, upa, upen, uprs and registered state. Engines must not combinationally loop eng_gnt back into eng_re.

## Structure
- Shared package up_ramcfg_pkg holds:
  - a clog2 function used for the starve counter and rr_ptr widths;
  - default constants for G_STARVE and G_NENG limits.
- Sub-module up_ramcfg_rrarb holds the parametric round-robin arbiter: G_NENG requests, pointer, one-hot winner and next pointer.
- Address compare, merge, starve logic and the pipeline stay in the top module.
- Flops are s_dff style with synchronous active-high reset.

## Test plan
1. G_NENG=2, eng_re=2'b11, eng_ra={5,3} for 4 cycles:
   - winners alternate 0,1,0,1, one-hot eng_gnt;
   - each eng_rvld appears 2 cycles later with mem[3] or mem[5].
2. Both engines and the CPU read address 7 in the same cycle:
   - eng_gnt=2'b11, a single omemre;
   - 2 cycles later eng_rvld=2'b11 and uprdy=1, all data = mem[7].
3. G_STARVE=4, continuous engine reads to 1/2, CPU read to 9:
   - the CPU is served in cycle 4 (counter saturated) with eng_gnt=0;
   - uprdy with mem[9] at cycle 6.
4. G_BYPASS=1, CPU write 0xA5A5 to address 4 while engine 0 reads 4:
   - omemre=0, omemwe=1;
   - eng_rdd=0xA5A5 with eng_rvld[0] 2 cycles later.
5. Pending CPU read latched behind engines, then upen=0:
   - latch and counter clear, no memory read, no uprdy.
6. rst asserted one cycle after a grant:
   - no eng_rvld or uprdy follows;
   - all outputs 0 and rr_ptr=0 next cycle.
